// File: rtl/pool_window_driver.sv
// pool_window_driver
//   Initiator side of a 2x2 pooling start/finish handshake. It walks a
//   MAP_N x MAP_N feature map in a synchronous input RAM at stride 2.
//   For each 2x2 window it reads the four words and presents them to the
//   pooling unit. It then waits for the pooled pixel and writes it, in
//   row-major order, into an output RAM of (MAP_N/2)^2 words.
//   An odd MAP_N ignores the last row and column.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   go               1-cycle pulse that starts a full pass (ignored while busy)
//   busy             high from the cycle after go until done
//   done             1-cycle pulse at the end of a pass (normal or aborted)
//   err              sticky watchdog flag, cleared by the next accepted go
//   rd_en/rd_addr    input RAM read strobe/address; rd_data arrives 1 cycle later
//   pool_start       request to the pooling unit
//   pool_win         5x5 window of 16-bit entries, row-major [x][y]; only
//                    [0][0],[0][1],[1][0],[1][1] are driven, the rest are 0
//   pool_finish      pooling unit done level; pool_pixel is valid while it is high
//   wr_en/wr_addr    output RAM write strobe/address
//   wr_data          pooled pixel captured from pool_pixel
//
// Optional feature
//   POOL_TIMEOUT_EN  enables a watchdog of TIMEOUT cycles on each handshake
//                    phase. On expiry it sets err and aborts the pass. When the
//                    macro is undefined, the phases wait forever and err is 0.
module pool_window_driver #(
  parameter int MAP_N   = 28,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              pool_start,
  output logic [25*16-1:0]  pool_win,
  input  logic              pool_finish,
  input  logic [15:0]       pool_pixel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data
);

  localparam int HALF = MAP_N / 2;
  localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(MAP_N);
  localparam logic [ADDR_W-1:0] HALF_A = ADDR_W'(HALF);
  localparam logic [ADDR_W-1:0] LAST   = (HALF > 0) ? ADDR_W'(HALF - 1) : '0;
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WRITE, S_RELEASE, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] win_r, win_c;
  logic [ADDR_W-1:0] nxt_r, nxt_c;
  logic [ADDR_W-1:0] base;
  logic              last_win;
  logic [2:0]        fcnt;
  logic [15:0]       w00, w01, w10, w11;

`ifdef POOL_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] wdog;
`else
  assign err = 1'b0;
`endif

  // Top-left input address of the window at output position (r, c).
  function automatic logic [ADDR_W-1:0] base_addr(input logic [ADDR_W-1:0] r,
                                                  input logic [ADDR_W-1:0] c);
    return ((r << 1) * N_A) + (c << 1);
  endfunction

  assign base     = base_addr(win_r, win_c);
  assign last_win = (win_r == LAST) && (win_c == LAST);
  assign nxt_c    = (win_c == LAST) ? '0 : win_c + ONE;
  assign nxt_r    = (win_c == LAST) ? win_r + ONE : win_r;

  always_comb begin
    pool_win          = '0;
    pool_win[0  +:16] = w00;
    pool_win[16 +:16] = w01;
    pool_win[80 +:16] = w10;
    pool_win[96 +:16] = w11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      pool_start <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      win_r      <= '0;
      win_c      <= '0;
      fcnt       <= '0;
      w00        <= '0;
      w01        <= '0;
      w10        <= '0;
      w11        <= '0;
`ifdef POOL_TIMEOUT_EN
      err        <= 1'b0;
      wdog       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            win_r <= '0;
            win_c <= '0;
`ifdef POOL_TIMEOUT_EN
            err   <= 1'b0;
`endif
            if (HALF == 0) begin
              // Degenerate map: nothing to pool, finish straight away.
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_FETCH;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= '0;
              fcnt    <= '0;
            end
          end
        end

        // Reads are issued in cycles 0..3; each word is captured one cycle later.
        S_FETCH: begin
          fcnt <= fcnt + 3'd1;
          case (fcnt)
            3'd0:    rd_addr <= base + ONE;
            3'd1:    rd_addr <= base + N_A;
            3'd2:    rd_addr <= base + N_A + ONE;
            3'd3:    rd_en   <= 1'b0;
            default: ;
          endcase
          case (fcnt)
            3'd1: w00 <= rd_data;
            3'd2: w01 <= rd_data;
            3'd3: w10 <= rd_data;
            3'd4: begin
              w11        <= rd_data;
              state      <= S_ISSUE;
              pool_start <= 1'b1;
`ifdef POOL_TIMEOUT_EN
              wdog       <= '0;
`endif
            end
            default: ;
          endcase
        end

        S_ISSUE: begin
          if (pool_finish) begin
            wr_data    <= pool_pixel;
            wr_addr    <= (win_r * HALF_A) + win_c;
            wr_en      <= 1'b1;
            pool_start <= 1'b0;
            state      <= S_WRITE;
          end
`ifdef POOL_TIMEOUT_EN
          else if (wdog == TO_LAST) begin
            err        <= 1'b1;
            pool_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            wdog <= wdog + 32'd1;
          end
`endif
        end

        S_WRITE: begin
          wr_en <= 1'b0;
          state <= S_RELEASE;
`ifdef POOL_TIMEOUT_EN
          wdog  <= '0;
`endif
        end

        // Wait for the pooling unit to drop finish before the next window.
        S_RELEASE: begin
          if (!pool_finish) begin
            if (last_win) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              win_r   <= nxt_r;
              win_c   <= nxt_c;
              rd_en   <= 1'b1;
              rd_addr <= base_addr(nxt_r, nxt_c);
              fcnt    <= '0;
              state   <= S_FETCH;
            end
          end
`ifdef POOL_TIMEOUT_EN
          else if (wdog == TO_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            wdog <= wdog + 32'd1;
          end
`endif
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_driver.sv
// Testbench for pool_window_driver. It runs three instances: MAP_N=4, MAP_N=5
// and MAP_N=1. Each instance has its own input RAM and its own pooling-unit
// model. The pooling unit returns the floor average of the four window
// entries. Several finish-timing behaviours are selectable per instance.
module tb_pool_window_driver;

  localparam int NI  = 3;
  localparam int AW  = 16;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]          go = '0;
  logic [NI-1:0]          busy, done, err, rd_en, pool_start, wr_en;
  logic [NI-1:0]          pool_finish = '0;
  logic [NI-1:0][AW-1:0]  rd_addr, wr_addr;
  logic [NI-1:0][15:0]    rd_data, pool_pixel, wr_data;
  logic [NI-1:0][399:0]   pool_win;

  for (genvar g = 0; g < NI; g++) begin : gi
    pool_window_driver #(
      .MAP_N   ((g == 0) ? 4 : ((g == 1) ? 5 : 1)),
      .ADDR_W  (AW),
      .TIMEOUT (TMO)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .go          (go[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .err         (err[g]),
      .rd_en       (rd_en[g]),
      .rd_addr     (rd_addr[g]),
      .rd_data     (rd_data[g]),
      .pool_start  (pool_start[g]),
      .pool_win    (pool_win[g]),
      .pool_finish (pool_finish[g]),
      .pool_pixel  (pool_pixel[g]),
      .wr_en       (wr_en[g]),
      .wr_addr     (wr_addr[g]),
      .wr_data     (wr_data[g])
    );
  end

  function automatic int map_n(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 5 : 1);
  endfunction

  function automatic logic [15:0] avg4(input logic [399:0] w);
    logic [17:0] s;
    s = {2'b00, w[15:0]} + {2'b00, w[31:16]} + {2'b00, w[95:80]} + {2'b00, w[111:96]};
    return s[17:2];
  endfunction

  function automatic logic [399:0] drv_mask();
    logic [399:0] m;
    m = '0;
    m[15:0] = '1; m[31:16] = '1; m[95:80] = '1; m[111:96] = '1;
    return m;
  endfunction

  // ---------------- environment: RAMs, pooling models, monitors -------------
  logic [15:0] ram [NI][64];
  int          mode [NI];          // 0 ideal, 1 hold finish, 2 never finish, 3 finish early
  int          cnt [NI], hcnt [NI];
  logic [NI-1:0] last_start = '0, last_done = '0;
  logic [31:0] wq [NI][$];
  int dcnt [NI], dwide [NI], rcnt [NI], badrd [NI], scnt [NI], zviol [NI];

  always_comb begin
    pool_pixel = '0;
    for (int g = 0; g < NI; g++) pool_pixel[g] = avg4(pool_win[g]);
  end

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      int n, lim, row, col;
      n = map_n(g);
      lim = 2 * (n / 2);
      if (rd_en[g]) begin
        rd_data[g] <= ram[g][rd_addr[g][5:0]];
        rcnt[g]    <= rcnt[g] + 1;
        row = int'(rd_addr[g]) / n;
        col = int'(rd_addr[g]) % n;
        if (row >= lim || col >= lim) badrd[g] <= badrd[g] + 1;
      end
      case (mode[g])
        0, 1: begin
          if (pool_start[g]) begin
            hcnt[g] <= 0;
            if (!pool_finish[g]) begin
              if (cnt[g] == 2) pool_finish[g] <= 1'b1;
              cnt[g] <= cnt[g] + 1;
            end
          end else begin
            cnt[g] <= 0;
            if (pool_finish[g]) begin
              if (mode[g] == 0 || hcnt[g] == 4) pool_finish[g] <= 1'b0;
              hcnt[g] <= hcnt[g] + 1;
            end
          end
        end
        2:       pool_finish[g] <= 1'b0;
        default: pool_finish[g] <= !(last_start[g] && !pool_start[g]);
      endcase
      last_start[g] <= pool_start[g];
      last_done[g]  <= done[g];
      if (wr_en[g]) wq[g].push_back({wr_addr[g], wr_data[g]});
      if (done[g]) dcnt[g] <= dcnt[g] + 1;
      if (done[g] && last_done[g]) dwide[g] <= dwide[g] + 1;
      if (pool_start[g]) begin
        scnt[g] <= scnt[g] + 1;
        if ((pool_win[g] & ~drv_mask()) != '0) zviol[g] <= zviol[g] + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------------------------------
  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic logic any_out(input int g);
    return busy[g] | done[g] | err[g] | rd_en[g] | pool_start[g] | wr_en[g] |
           (|rd_addr[g]) | (|wr_addr[g]) | (|wr_data[g]) | (|pool_win[g]);
  endfunction

  task automatic pulse_go(input int g);
    @(negedge clk); go[g] = 1'b1;
    @(negedge clk); go[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int d0, input string nm);
    int k = 0;
    while (dcnt[g] == d0 && k < 3000) begin @(negedge clk); k++; end
    check({nm, " done_seen"}, longint'(dcnt[g] > d0), 1);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] wq_at(input int g, input int i);
    return (i < wq[g].size()) ? wq[g][i] : 32'hFFFF_FFFF;
  endfunction

  task automatic fill_ramp(input int g);
    for (int a = 0; a < 64; a++) ram[g][a] = 16'(a);
  endtask

  // Expected pixel from the map contents: floor mean of the 2x2 block.
  function automatic logic [15:0] ref_pix(input int g, input int r, input int c);
    int n, s;
    n = map_n(g);
    s = ram[g][(2*r)*n + 2*c] + ram[g][(2*r)*n + 2*c + 1] +
        ram[g][(2*r+1)*n + 2*c] + ram[g][(2*r+1)*n + 2*c + 1];
    return 16'(s / 4);
  endfunction

  typedef struct {
    int          g;
    int          md;
    int          nw;
    logic [15:0] ex [4];
  } vec_t;

  vec_t tbl [5];

  task automatic set_vec(input int i, input int g, input int md, input int nw,
                         input int e0, input int e1, input int e2, input int e3);
    tbl[i].g = g; tbl[i].md = md; tbl[i].nw = nw;
    tbl[i].ex[0] = 16'(e0); tbl[i].ex[1] = 16'(e1);
    tbl[i].ex[2] = 16'(e2); tbl[i].ex[3] = 16'(e3);
  endtask

  initial begin
    int g, b, d0, r0, bd0, s0, k;
    for (int i = 0; i < NI; i++) mode[i] = 0;
    set_vec(0, 0, 0, 4,  2,  4, 10, 12);
    set_vec(1, 0, 1, 4,  2,  4, 10, 12);
    set_vec(2, 0, 3, 4,  2,  4, 10, 12);
    set_vec(3, 1, 0, 4,  3,  5, 13, 15);
    set_vec(4, 2, 0, 0,  0,  0,  0,  0);

    // Reset state
    #12;
    for (int i = 0; i < NI; i++) check($sformatf("reset_outputs[%0d]", i), any_out(i), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven passes
    foreach (tbl[i]) begin
      g = tbl[i].g;
      fill_ramp(g);
      mode[g] = tbl[i].md;
      b = wq[g].size(); d0 = dcnt[g]; r0 = rcnt[g]; bd0 = badrd[g];
      pulse_go(g);
      if (tbl[i].nw > 0) check($sformatf("vec%0d busy_after_go", i), busy[g], 1);
      else               check($sformatf("vec%0d done_next_cycle", i), done[g], 1);
      wait_done(g, d0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d n_writes", i), wq[g].size() - b, tbl[i].nw);
      for (int j = 0; j < tbl[i].nw; j++) begin
        check($sformatf("vec%0d wr_addr[%0d]", i, j), wq_at(g, b + j) >> 16, j);
        check($sformatf("vec%0d wr_data[%0d]", i, j), wq_at(g, b + j) & 32'hFFFF, tbl[i].ex[j]);
      end
      check($sformatf("vec%0d done_count", i), dcnt[g] - d0, 1);
      check($sformatf("vec%0d busy_end", i), busy[g], 0);
      check($sformatf("vec%0d reads", i), rcnt[g] - r0, 4 * tbl[i].nw);
      check($sformatf("vec%0d out_of_range_reads", i), badrd[g] - bd0, 0);
      check($sformatf("vec%0d err", i), err[g], 0);
    end

    // go pulsed again in the middle of a pass
    mode[0] = 0; fill_ramp(0);
    b = wq[0].size(); d0 = dcnt[0];
    pulse_go(0);
    repeat (20) @(negedge clk);
    pulse_go(0);
    wait_done(0, d0, "midgo");
    repeat (30) @(negedge clk);
    check("midgo n_writes", wq[0].size() - b, 4);
    check("midgo done_count", dcnt[0] - d0, 1);
    check("midgo busy_idle", busy[0], 0);

    // Asynchronous reset while the second window is in ISSUE
    b = wq[0].size(); d0 = dcnt[0];
    pulse_go(0);
    k = 0;
    while (!(wq[0].size() - b == 1 && pool_start[0]) && k < 500) begin @(negedge clk); k++; end
    check("rst_mid reached_issue2", longint'(k < 500), 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid outputs_zero", any_out(0), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    b = wq[0].size(); d0 = dcnt[0];
    pulse_go(0);
    wait_done(0, d0, "rst_mid rerun");
    check("rst_mid n_writes", wq[0].size() - b, 4);
    for (int j = 0; j < 4; j++)
      check($sformatf("rst_mid wr_data[%0d]", j), wq_at(0, b + j) & 32'hFFFF, 32'(2 + 2*(j%2) + 8*(j/2)));

    // Randomized maps and finish timing against the reference mean
    for (int it = 0; it < 6; it++) begin
      int n, h, pick;
      g = it % 2;
      n = map_n(g); h = n / 2;
      for (int a = 0; a < 64; a++) ram[g][a] = 16'($urandom);
      pick = int'($urandom_range(0, 2));
      mode[g] = (pick == 2) ? 3 : pick;
      b = wq[g].size(); d0 = dcnt[g];
      pulse_go(g);
      wait_done(g, d0, $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d n_writes", it), wq[g].size() - b, h * h);
      for (int r = 0; r < h; r++)
        for (int c = 0; c < h; c++) begin
          check($sformatf("rnd%0d addr(%0d,%0d)", it, r, c), wq_at(g, b + r*h + c) >> 16, r*h + c);
          check($sformatf("rnd%0d pix(%0d,%0d)", it, r, c), wq_at(g, b + r*h + c) & 32'hFFFF, ref_pix(g, r, c));
        end
    end

`ifdef POOL_TIMEOUT_EN
    // Pooling unit that never answers
    mode[0] = 2; fill_ramp(0);
    b = wq[0].size(); d0 = dcnt[0]; s0 = scnt[0]; r0 = rcnt[0];
    pulse_go(0);
    wait_done(0, d0, "timeout");
    check("timeout err", err[0], 1);
    check("timeout issue_cycles", scnt[0] - s0, TMO);
    check("timeout n_writes", wq[0].size() - b, 0);
    check("timeout reads", rcnt[0] - r0, 4);
    check("timeout done_count", dcnt[0] - d0, 1);
    mode[0] = 0;
    b = wq[0].size(); d0 = dcnt[0];
    pulse_go(0);
    check("timeout err_cleared", err[0], 0);
    wait_done(0, d0, "timeout rerun");
    check("timeout rerun n_writes", wq[0].size() - b, 4);
`endif

    for (int i = 0; i < NI; i++) begin
      check($sformatf("done_single_cycle[%0d]", i), dwide[i], 0);
      check($sformatf("win_undriven_zero[%0d]", i), zviol[i], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
